data_mem_controller: RTL and testbench
======================================

// Module: data_mem_controller
// PURPOSE
//   Shares the single data-memory port of the GPU among NUM_CONSUMERS load/store units (LSUs), one per thread.
//   Round-robin arbitration; one memory transaction (read or write) in flight at a time.
//   Sits inside top, between the per-thread LSUs and the flattened data_mem_* ports.
//   Uses the same level valid/ready handshake as the data_mem_* ports.
// PARAMETERS
//   NUM_CONSUMERS  4  number of LSU requesters (>=2)
//   ADDR_BITS      8  data-memory address width
//   DATA_BITS      8  data-memory word width
// PORTS
//   clk                    in   1            clock, all state on posedge
//   reset                  in   1            asynchronous, active-high
//   consumer_read_valid    in   N            per-LSU read request
//   consumer_read_address  in   N*ADDR_BITS  LSU i at [i*ADDR_BITS +: ADDR_BITS]
//   consumer_read_ready    out  N            per-LSU read complete
//   consumer_read_data     out  N*DATA_BITS  read result, LSU i slice
//   consumer_write_valid   in   N            per-LSU write request
//   consumer_write_address in   N*ADDR_BITS  write address slices
//   consumer_write_data    in   N*DATA_BITS  write data slices
//   consumer_write_ready   out  N            per-LSU write complete
//   mem_read_valid         out  1            to data_mem_read_valid
//   mem_read_address       out  ADDR_BITS    to data_mem_read_address
//   mem_read_ready         in   1            from data_mem_read_ready
//   mem_read_data          in   DATA_BITS    from data_mem_read_data, valid with ready
//   mem_write_valid        out  1            to data_mem_write_valid
//   mem_write_address      out  ADDR_BITS    to data_mem_write_address
//   mem_write_data         out  DATA_BITS    to data_mem_write_data
//   mem_write_ready        in   1            from data_mem_write_ready
//   busy                   out  1            high whenever state != IDLE
// BEHAVIOUR
//   Reset: all outputs registered and 0. State=IDLE, rr_ptr=0, grant index=0. consumer_read_data=0.
//   Reset mid-transaction: the in-flight access is dropped and mem_*_valid falls immediately. No ready is issued.
//   States:
//     IDLE       pick first i (from rr_ptr, ascending, wrapping N-1->0) with read_valid|write_valid.
//                Latch i, address, data. Read wins if both are set for the same i.
//                Assert mem_read_valid or mem_write_valid the next cycle and go to READ_WAIT or WRITE_WAIT.
//                mem_*_ready is ignored in IDLE.
//     READ_WAIT  hold mem_read_valid and mem_read_address until mem_read_ready=1 is sampled.
//                At that edge: capture mem_read_data into slice i, set consumer_read_ready[i]=1,
//                clear mem_read_valid, go to RELAY.
//     WRITE_WAIT hold valid, address and data until mem_write_ready=1 is sampled.
//                At that edge: set consumer_write_ready[i]=1, clear mem_write_valid, go to RELAY.
//     RELAY      hold ready[i] until the granted valid[i] is sampled 0.
//                Then clear ready[i], set rr_ptr=(i+1) mod N, go to IDLE.
//   Latency with a 1-cycle-ready memory:
//     valid sampled at edge k -> mem valid after k -> ready[i] after k+2.
//     Consumer drop seen at k+4 -> IDLE; next grant issues at k+5.
//   A request latched in IDLE is committed. If the consumer drops valid early, the access still completes
//   and ready[i] is high for exactly 1 cycle.
//   No wait limit: the controller stalls indefinitely in *_WAIT while mem ready stays low.
//   consumer_read_data[i] keeps its last value until the next read for i completes.
//   At most one bit of consumer_*_ready is high at any time. mem_read_valid and mem_write_valid are never high together.
// STRUCTURE
//   data_mem_defs.vh: state encodings (IDLE=2'd0, READ_WAIT=1, WRITE_WAIT=2, RELAY=3) and slice macros.
//   Sub-module rr_priority_picker: combinational, (req[N], rr_ptr) -> (found, idx). Reusable for a later program-memory controller.
//   Remaining logic (FSM, latches, output regs) stays in data_mem_controller.
// TESTING (N=4, 1-cycle-ready memory model, mem[a]=a^8'h5A preload)
//   1. Single read: LSU2 reads 0x10 -> read_ready[2] at k+2, data 0x4A. busy rises after k and falls after k+4.
//   2. Single write: LSU0 writes 0x33 to 0x80; then LSU0 reads 0x80 -> 0x33.
//      Only one mem valid is high during either access.
//   3. Contention: all 4 read 0x00..0x03 in the same cycle -> grants in order 0,1,2,3.
//      Each receives 0x5A,0x5B,0x58,0x59, each exactly once.
//   4. Fairness/wrap: rr_ptr=3, LSU0 and LSU3 request -> LSU3 first, then LSU0.
//      Then rr_ptr=1 and LSU0 waits behind LSU1 when both request.
//   5. Stall and early drop: hold mem ready low for 20 cycles -> valid and address stay stable.
//      LSU drops valid mid-wait -> access completes and ready pulses 1 cycle.
//   6. Reset in READ_WAIT: assert reset between edges -> mem_read_valid=0 immediately, all outputs 0.
//      After release, a new read succeeds.

Source files
------------

// File: rtl/data_mem_controller_pkg.sv
`default_nettype none
// data_mem_controller_pkg: FSM state encoding and round-robin index helper shared
// by the data-memory controller and its priority picker.
package data_mem_controller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_controller_rr_priority_picker.sv
`default_nettype none
// rr_priority_picker: combinational round-robin search; returns the first set
// request at or after rr_ptr, wrapping from N-1 back to 0.
module rr_priority_picker
  import data_mem_controller_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_BITS = 2
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] rr_ptr,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  logic [IDX_BITS-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_BITS'(rr_index(32'(rr_ptr), k, N));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_controller.sv
`default_nettype none
// data_mem_controller: round-robin arbiter sharing one data-memory port among
// NUM_CONSUMERS LSUs, with a single read or write transaction in flight.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic                               busy
);

  localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

  state_t                             state, state_next;
  logic [IDX_BITS-1:0]                rr_ptr, rr_ptr_next;
  logic [IDX_BITS-1:0]                grant_idx, grant_idx_next;
  logic                               grant_read, grant_read_next;
  logic [NUM_CONSUMERS-1:0]           read_ready_next, write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_next;
  logic                               mem_read_valid_next, mem_write_valid_next;
  logic [ADDR_BITS-1:0]               mem_read_address_next, mem_write_address_next;
  logic [DATA_BITS-1:0]               mem_write_data_next;
  logic                               busy_next;
  logic                               granted_valid;

  logic [NUM_CONSUMERS-1:0] req;
  logic                     pick_found;
  logic [IDX_BITS-1:0]      pick_idx;

  assign req = consumer_read_valid | consumer_write_valid;

  rr_priority_picker #(
    .N        (NUM_CONSUMERS),
    .IDX_BITS (IDX_BITS)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_next             = state;
    rr_ptr_next            = rr_ptr;
    grant_idx_next         = grant_idx;
    grant_read_next        = grant_read;
    read_ready_next        = consumer_read_ready;
    write_ready_next       = consumer_write_ready;
    read_data_next         = consumer_read_data;
    mem_read_valid_next    = mem_read_valid;
    mem_write_valid_next   = mem_write_valid;
    mem_read_address_next  = mem_read_address;
    mem_write_address_next = mem_write_address;
    mem_write_data_next    = mem_write_data;
    granted_valid = grant_read ? consumer_read_valid[grant_idx]
                               : consumer_write_valid[grant_idx];

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_idx_next = pick_idx;
          // A read takes precedence when one LSU raises both requests.
          if (consumer_read_valid[pick_idx]) begin
            grant_read_next       = 1'b1;
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
            state_next            = READ_WAIT;
          end else begin
            grant_read_next        = 1'b0;
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
            mem_write_data_next    = consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
            state_next             = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          read_data_next[grant_idx*DATA_BITS +: DATA_BITS] = mem_read_data;
          read_ready_next[grant_idx] = 1'b1;
          mem_read_valid_next        = 1'b0;
          state_next                 = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          write_ready_next[grant_idx] = 1'b1;
          mem_write_valid_next        = 1'b0;
          state_next                  = RELAY;
        end
      end
      RELAY: begin
        if (!granted_valid) begin
          read_ready_next  = '0;
          write_ready_next = '0;
          rr_ptr_next      = IDX_BITS'(rr_index(32'(grant_idx), 1, NUM_CONSUMERS));
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_idx            <= '0;
      grant_read           <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      mem_read_valid       <= 1'b0;
      mem_write_valid      <= 1'b0;
      mem_read_address     <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_next;
      rr_ptr               <= rr_ptr_next;
      grant_idx            <= grant_idx_next;
      grant_read           <= grant_read_next;
      consumer_read_ready  <= read_ready_next;
      consumer_write_ready <= write_ready_next;
      consumer_read_data   <= read_data_next;
      mem_read_valid       <= mem_read_valid_next;
      mem_write_valid      <= mem_write_valid_next;
      mem_read_address     <= mem_read_address_next;
      mem_write_address    <= mem_write_address_next;
      mem_write_data       <= mem_write_data_next;
      busy                 <= busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// Bench for data_mem_controller: 1-cycle-ready memory preloaded with a^8'h5A and
// a round-robin reference model predicting grant order and returned data.
module tb_data_mem_controller;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]   consumer_read_valid    = '0;
  logic [N-1:0]   consumer_write_valid   = '0;
  logic [N*8-1:0] consumer_read_address  = '0;
  logic [N*8-1:0] consumer_write_address = '0;
  logic [N*8-1:0] consumer_write_data    = '0;
  logic [N-1:0]   consumer_read_ready, consumer_write_ready;
  logic [N*8-1:0] consumer_read_data;
  logic           mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready, busy;
  logic [7:0]     mem_read_address, mem_read_data, mem_write_address, mem_write_data;
  logic           stall = 1'b0;

  logic [7:0] mem_array [256];
  logic [7:0] ref_mem   [256];
  int compared = 0, mismatched = 0, inv_err = 0, model_ptr = 0;
  int         exp_idx[$], obs_idx[$];
  bit         exp_rd[$],  obs_rd[$];
  logic [7:0] exp_data[$], obs_data[$];

  data_mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  // Memory: ready one cycle after valid is seen, read data presented with ready.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_ready  <= 1'b0;
      mem_write_ready <= 1'b0;
      mem_read_data   <= '0;
      for (int a = 0; a < 256; a++) mem_array[a] <= 8'(a) ^ 8'h5A;
    end else begin
      mem_read_ready  <= mem_read_valid && !mem_read_ready && !stall;
      mem_read_data   <= mem_array[mem_read_address];
      mem_write_ready <= mem_write_valid && !mem_write_ready && !stall;
      if (mem_write_valid && mem_write_ready) mem_array[mem_write_address] <= mem_write_data;
    end
  end

  task automatic model_init();
    model_ptr = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'h5A;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  task automatic set_read(input int i, input logic [7:0] a);
    consumer_read_address[i*8 +: 8] = a;
    consumer_read_valid[i] = 1'b1;
  endtask

  task automatic set_write(input int i, input logic [7:0] a, input logic [7:0] d);
    consumer_write_address[i*8 +: 8] = a;
    consumer_write_data[i*8 +: 8]    = d;
    consumer_write_valid[i] = 1'b1;
  endtask

  // Reference: serve pending requests in round-robin order, read before write per LSU.
  task automatic predict();
    bit prd[N];
    bit pwr[N];
    bit any;
    int pick;
    exp_idx.delete(); exp_rd.delete(); exp_data.delete();
    for (int i = 0; i < N; i++) begin
      prd[i] = consumer_read_valid[i];
      pwr[i] = consumer_write_valid[i];
    end
    do begin
      any = 0; pick = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (model_ptr + k) % N;
        if (!any && (prd[c] || pwr[c])) begin any = 1; pick = c; end
      end
      if (any) begin
        exp_idx.push_back(pick);
        if (prd[pick]) begin
          exp_rd.push_back(1'b1);
          exp_data.push_back(ref_mem[consumer_read_address[pick*8 +: 8]]);
          prd[pick] = 0;
        end else begin
          ref_mem[consumer_write_address[pick*8 +: 8]] = consumer_write_data[pick*8 +: 8];
          exp_rd.push_back(1'b0);
          exp_data.push_back(consumer_write_data[pick*8 +: 8]);
          pwr[pick] = 0;
        end
        model_ptr = (pick + 1) % N;
      end
    end while (any);
  endtask

  // LSU agents: drop valid once ready is seen; record completions in order.
  task automatic serve(input int max_cycles);
    int cyc;
    bit done;
    cyc = 0; done = 0;
    obs_idx.delete(); obs_rd.delete(); obs_data.delete();
    while (!done) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if ($countones({consumer_read_ready, consumer_write_ready}) > 1) inv_err++;
      if (mem_read_valid && mem_write_valid) inv_err++;
      for (int i = 0; i < N; i++) begin
        if (consumer_read_ready[i]) begin
          if (!consumer_read_valid[i]) inv_err++;
          obs_idx.push_back(i); obs_rd.push_back(1'b1);
          obs_data.push_back(consumer_read_data[i*8 +: 8]);
          consumer_read_valid[i] = 1'b0;
        end
        if (consumer_write_ready[i]) begin
          if (!consumer_write_valid[i]) inv_err++;
          obs_idx.push_back(i); obs_rd.push_back(1'b0);
          obs_data.push_back(consumer_write_data[i*8 +: 8]);
          consumer_write_valid[i] = 1'b0;
        end
      end
      if (consumer_read_valid == '0 && consumer_write_valid == '0 && !busy) done = 1;
      else if (cyc >= max_cycles) begin
        compared++; mismatched++;
        $display("FAIL serve_timeout: got no completion after %0d cycles, required all requests done", cyc);
        consumer_read_valid = '0; consumer_write_valid = '0;
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({mem_read_valid, mem_write_valid, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_valids: got %b required 000", {mem_read_valid, mem_write_valid, busy});
    end
    compared++;
    if ({consumer_read_ready, consumer_write_ready} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_readies: got %h required 00", {consumer_read_ready, consumer_write_ready});
    end
    compared++;
    if ({consumer_read_data, mem_read_address, mem_write_address, mem_write_data} !== 56'h0) begin
      mismatched++;
      $display("FAIL reset_data: got %h required 0",
               {consumer_read_data, mem_read_address, mem_write_address, mem_write_data});
    end
    reset = 1'b0;
    model_init();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_read(2, 8'h10);
    @(posedge clk); @(negedge clk);
    compared++;
    if ({busy, mem_read_valid, mem_read_address, consumer_read_ready} !== {1'b1, 1'b1, 8'h10, 4'b0000}) begin
      mismatched++;
      $display("FAIL read_issue_k: got busy=%b mrv=%b addr=%h rdy=%b required 1 1 10 0000",
               busy, mem_read_valid, mem_read_address, consumer_read_ready);
    end
    @(posedge clk); @(negedge clk);
    compared++;
    if (consumer_read_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL read_ready_k1: got %b required 0000", consumer_read_ready);
    end
    @(posedge clk); @(negedge clk);
    compared++;
    if (consumer_read_ready !== 4'b0100 || consumer_read_data[23:16] !== 8'h4A) begin
      mismatched++;
      $display("FAIL read_ready_k2: got rdy=%b data=%h required 0100 4A",
               consumer_read_ready, consumer_read_data[23:16]);
    end
    @(posedge clk); @(negedge clk);
    compared++;
    if (busy !== 1'b1 || consumer_read_ready !== 4'b0100) begin
      mismatched++;
      $display("FAIL read_hold_k3: got busy=%b rdy=%b required 1 0100", busy, consumer_read_ready);
    end
    consumer_read_valid[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    compared++;
    if (busy !== 1'b0 || consumer_read_ready !== 4'b0000) begin
      mismatched++;
      $display("FAIL read_done_k4: got busy=%b rdy=%b required 0 0000", busy, consumer_read_ready);
    end
    model_ptr = (2 + 1) % N;
  endtask

  task automatic test_single_write();
    set_write(0, 8'h80, 8'h33);
    predict();
    serve(50);
    compared++;
    if (obs_idx.size() != 1 || obs_idx[0] !== 0 || obs_rd[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL write_complete: got %0d completions required one write by lsu0", obs_idx.size());
    end
    set_read(0, 8'h80);
    predict();
    serve(50);
    compared++;
    if (obs_data.size() != 1) begin
      mismatched++;
      $display("FAIL write_readback: got %0d completions required 1", obs_data.size());
    end else if (obs_data[0] !== exp_data[0] || obs_data[0] !== 8'h33) begin
      mismatched++;
      $display("FAIL write_readback: got %h required 33", obs_data[0]);
    end
    compared++;
    if (inv_err !== 0) begin
      mismatched++;
      $display("FAIL write_exclusive: got %0d invariant violations required 0", inv_err);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < N; i++) set_read(i, 8'(i));
    predict();
    serve(100);
    compared++;
    if (obs_idx.size() != exp_idx.size()) begin
      mismatched++;
      $display("FAIL contention_count: got %0d required %0d", obs_idx.size(), exp_idx.size());
    end else begin
      for (int j = 0; j < exp_idx.size(); j++) begin
        compared++;
        if (obs_idx[j] !== exp_idx[j] || obs_rd[j] !== exp_rd[j] || obs_data[j] !== exp_data[j]) begin
          mismatched++;
          $display("FAIL contention_grant%0d: got lsu%0d rd=%0d data=%h required lsu%0d rd=%0d data=%h",
                   j, obs_idx[j], obs_rd[j], obs_data[j], exp_idx[j], exp_rd[j], exp_data[j]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    set_read(2, 8'h05);
    predict();
    serve(50);
    for (int round = 0; round < 2; round++) begin
      int first_lsu;
      if (round == 0) begin
        set_read(0, 8'h40); set_read(3, 8'h43); first_lsu = 3;
      end else begin
        set_read(0, 8'h50); set_write(1, 8'h51, 8'hC3); first_lsu = 1;
      end
      predict();
      serve(100);
      compared++;
      if (obs_idx.size() != 2 || obs_idx[0] !== first_lsu) begin
        mismatched++;
        $display("FAIL fairness_first_r%0d: got %0d completions first=%0d required 2 first=%0d",
                 round, obs_idx.size(), (obs_idx.size() > 0) ? obs_idx[0] : -1, first_lsu);
      end else begin
        for (int j = 0; j < 2; j++) begin
          compared++;
          if (obs_idx[j] !== exp_idx[j] || obs_rd[j] !== exp_rd[j] || obs_data[j] !== exp_data[j]) begin
            mismatched++;
            $display("FAIL fairness_r%0d_grant%0d: got lsu%0d data=%h required lsu%0d data=%h",
                     round, j, obs_idx[j], obs_data[j], exp_idx[j], exp_data[j]);
          end
        end
      end
    end
  endtask

  task automatic test_stall_early_drop();
    bit stable;
    int pulses;
    logic [7:0] got;
    stall = 1'b1;
    set_read(1, 8'h42);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h42 || mem_write_valid !== 1'b0 ||
          consumer_read_ready !== 4'b0000) stable = 0;
      if (c == 9) consumer_read_valid[1] = 1'b0;
    end
    compared++;
    if (!stable) begin
      mismatched++;
      $display("FAIL stall_hold: got unstable valid/address (now mrv=%b addr=%h) required 1 42",
               mem_read_valid, mem_read_address);
    end
    stall = 1'b0;
    pulses = 0; got = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (consumer_read_ready[1]) begin pulses++; got = consumer_read_data[15:8]; end
    end
    compared++;
    if (pulses !== 1) begin
      mismatched++;
      $display("FAIL early_drop_pulse: got %0d ready cycles required 1", pulses);
    end
    compared++;
    if (got !== ref_mem[8'h42]) begin
      mismatched++;
      $display("FAIL early_drop_data: got %h required %h", got, ref_mem[8'h42]);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL early_drop_idle: got busy=%b required 0", busy);
    end
    model_ptr = (1 + 1) % N;
  endtask

  task automatic test_reset_mid_read();
    stall = 1'b1;
    set_read(0, 8'h20);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    compared++;
    if (mem_read_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_pre: got mrv=%b required 1", mem_read_valid);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (mem_read_valid !== 1'b0 || busy !== 1'b0 || mem_write_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_valid: got mrv=%b busy=%b mwv=%b required 0 0 0",
               mem_read_valid, busy, mem_write_valid);
    end
    compared++;
    if ({consumer_read_ready, consumer_write_ready} !== 8'h00 || consumer_read_data !== 32'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got rdy=%h data=%h required 00 00000000",
               {consumer_read_ready, consumer_write_ready}, consumer_read_data);
    end
    consumer_read_valid = '0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
    set_read(3, 8'h21);
    predict();
    serve(50);
    compared++;
    if (obs_data.size() != 1 || obs_idx[0] !== 3 || obs_data[0] !== exp_data[0]) begin
      mismatched++;
      $display("FAIL midreset_after: got %0d completions data=%h required 1 from lsu3 data=%h",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 8'h00, exp_data[0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int op;
        op = int'($urandom_range(0, 4));
        if (op == 1 || op == 2 || op == 4) set_read(i, 8'($urandom_range(0, 15)));
        if (op == 3 || op == 4) set_write(i, 8'($urandom_range(0, 15)), 8'($urandom));
      end
      if (consumer_read_valid == '0 && consumer_write_valid == '0) set_read(r % N, 8'(r));
      predict();
      serve(200);
      compared++;
      if (obs_idx.size() != exp_idx.size()) begin
        mismatched++;
        $display("FAIL random_r%0d_count: got %0d required %0d", r, obs_idx.size(), exp_idx.size());
      end else begin
        for (int j = 0; j < exp_idx.size(); j++) begin
          compared++;
          if (obs_idx[j] !== exp_idx[j] || obs_rd[j] !== exp_rd[j] || obs_data[j] !== exp_data[j]) begin
            mismatched++;
            $display("FAIL random_r%0d_op%0d: got lsu%0d rd=%0d data=%h required lsu%0d rd=%0d data=%h",
                     r, j, obs_idx[j], obs_rd[j], obs_data[j], exp_idx[j], exp_rd[j], exp_data[j]);
          end
        end
      end
    end
  endtask

  task automatic test_invariants();
    compared++;
    if (inv_err !== 0) begin
      mismatched++;
      $display("FAIL invariants: got %0d violations required 0", inv_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_fairness();
    test_stall_early_drop();
    test_reset_mid_read();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time %0t required completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
